// File: rtl/washer_control_panel.sv
// Washing-machine front panel: synchronises and debounces the buttons and switches,
// latches program options for a whole cycle and runs the start/done launch handshake.
module washer_control_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LAUNCH_TIMEOUT  = 8,
  parameter int BEEP_CYCLES     = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start,
  input  logic btn_pause,
  input  logic sw_double,
  input  logic sw_dry,
  input  logic done,
  output logic start,
  output logic double_wash,
  output logic dry_wash,
  output logic time_pause,
  output logic door_lock,
  output logic finish_beep,
  output logic fault
);

  localparam int NIN  = 4;
  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (LAUNCH_TIMEOUT > BEEP_CYCLES) ? LAUNCH_TIMEOUT : BEEP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] LAUNCH_LAST = TW'(LAUNCH_TIMEOUT - 1);
  localparam logic [TW-1:0] BEEP_LAST   = TW'(BEEP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    FINISH = 3'd4,
    FAULT  = 3'd5
  } state_e;

  // Bit order of the input vectors: 0 start, 1 pause, 2 double, 3 dry.
  logic [NIN-1:0] raw_s;
  logic [NIN-1:0] sync1_q;
  logic [NIN-1:0] sync2_q;
  logic [NIN-1:0] deb_q;
  logic [NIN-1:0] deb_d;
  logic [CW-1:0]  cnt_q [NIN];
  logic [CW-1:0]  cnt_d [NIN];
  logic [1:0]     deb_prev_q;
  logic           press_start_s;
  logic           press_pause_s;

  state_e         state_q;
  state_e         state_d;
  logic [TW-1:0]  timer_q;
  logic [TW-1:0]  timer_d;
  logic           double_q;
  logic           double_d;
  logic           dry_q;
  logic           dry_d;
  logic           start_q;
  logic           start_d;
  logic           pause_q;
  logic           pause_d;
  logic           lock_q;
  logic           lock_d;
  logic           beep_q;
  logic           beep_d;
  logic           fault_q;
  logic           fault_d;

  assign raw_s = {sw_dry, sw_double, btn_pause, btn_start};

  // Debounce: count consecutive synced cycles that disagree with the debounced value.
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Synchroniser, debounce state and button edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q[1:0];
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign press_start_s = deb_q[0] & ~deb_prev_q[0];
  assign press_pause_s = deb_q[1] & ~deb_prev_q[1];

  // State, shared timer, latched options and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      double_q <= 1'b0;
      dry_q    <= 1'b0;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      lock_q   <= 1'b0;
      beep_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      double_q <= double_d;
      dry_q    <= dry_d;
      start_q  <= start_d;
      pause_q  <= pause_d;
      lock_q   <= lock_d;
      beep_q   <= beep_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state logic; done outranks a same-cycle pause press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (press_start_s) begin
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        if (!done) begin
          state_d = RUN;
        end else if (timer_q == LAUNCH_LAST) begin
          state_d = FAULT;
        end else begin
          state_d = LAUNCH;
        end
      end
      RUN: begin
        if (done) begin
          state_d = FINISH;
        end else if (press_pause_s) begin
          state_d = PAUSED;
        end else begin
          state_d = RUN;
        end
      end
      PAUSED: begin
        if (done) begin
          state_d = FINISH;
        end else if (press_pause_s) begin
          state_d = RUN;
        end else begin
          state_d = PAUSED;
        end
      end
      FINISH: begin
        if (timer_q == BEEP_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = FINISH;
        end
      end
      FAULT: begin
        if (press_start_s) begin
          state_d = IDLE;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Timer runs only while staying in LAUNCH or FINISH; it restarts from zero on entry.
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) && ((state_q == LAUNCH) || (state_q == FINISH))) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end
  end

  // Options follow the switches only while idle, frozen for the rest of the cycle.
  always_comb begin
    double_d = double_q;
    dry_d    = dry_q;
    if (state_d == IDLE) begin
      double_d = deb_q[2];
      dry_d    = deb_q[3];
    end else begin
      double_d = double_q;
      dry_d    = dry_q;
    end
  end

  // Moore outputs decoded from the upcoming state.
  always_comb begin
    start_d = 1'b0;
    pause_d = 1'b0;
    lock_d  = 1'b0;
    beep_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      IDLE: begin
        start_d = 1'b0;
      end
      LAUNCH: begin
        start_d = 1'b1;
        lock_d  = 1'b1;
      end
      RUN: begin
        lock_d = 1'b1;
      end
      PAUSED: begin
        pause_d = 1'b1;
        lock_d  = 1'b1;
      end
      FINISH: begin
        beep_d = 1'b1;
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        start_d = 1'b0;
      end
    endcase
  end

  assign start       = start_q;
  assign double_wash = double_q;
  assign dry_wash    = dry_q;
  assign time_pause  = pause_q;
  assign door_lock   = lock_q;
  assign finish_beep = beep_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_washer_control_panel.sv
// Directed bench for washer_control_panel with default parameters; done is driven
// by hand as a simple controller model.
module tb_washer_control_panel;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_start;
  logic btn_pause;
  logic sw_double;
  logic sw_dry;
  logic done;
  logic start;
  logic double_wash;
  logic dry_wash;
  logic time_pause;
  logic door_lock;
  logic finish_beep;
  logic fault;

  int checks   = 0;
  int failures = 0;

  washer_control_panel dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .sw_double   (sw_double),
    .sw_dry      (sw_dry),
    .done        (done),
    .start       (start),
    .double_wash (double_wash),
    .dry_wash    (dry_wash),
    .time_pause  (time_pause),
    .door_lock   (door_lock),
    .finish_beep (finish_beep),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge passes; outputs are then sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_start"}, start, 32'd0);
    check_val({tag, "_dw"}, double_wash, 32'd0);
    check_val({tag, "_dry"}, dry_wash, 32'd0);
    check_val({tag, "_tp"}, time_pause, 32'd0);
    check_val({tag, "_lock"}, door_lock, 32'd0);
    check_val({tag, "_beep"}, finish_beep, 32'd0);
    check_val({tag, "_fault"}, fault, 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_start"}, start, 32'd0);
    check_val({tag, "_tp"}, time_pause, 32'd0);
    check_val({tag, "_lock"}, door_lock, 32'd0);
    check_val({tag, "_beep"}, finish_beep, 32'd0);
    check_val({tag, "_fault"}, fault, 32'd0);
  endtask

  task automatic wait_start(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((start !== 1'b1) && (n < max_cycles)) begin
      tick();
      n++;
    end
    check_val({tag, "_start_seen"}, start, 32'd1);
  endtask

  // Press start, let the controller drop done one cycle later, end up in RUN.
  task automatic launch_run(input string tag);
    btn_start = 1'b1;
    wait_start(tag, 12);
    done = 1'b0;
    tick();
    btn_start = 1'b0;
    check_val({tag, "_run_start"}, start, 32'd0);
    check_val({tag, "_run_lock"}, door_lock, 32'd1);
  endtask

  initial begin
    int beep_n;
    int hits;
    int n;

    rst_n     = 1'b0;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    sw_double = 1'b0;
    sw_dry    = 1'b0;
    done      = 1'b1;
    tick();
    tick();
    check_all_zero("rst");
    rst_n = 1'b1;

    // Nominal cycle with double wash selected.
    sw_double = 1'b1;
    repeat (8) tick();
    check_val("t1_dw_track", double_wash, 32'd1);
    check_val("t1_dry_track", dry_wash, 32'd0);
    btn_start = 1'b1;
    repeat (6) tick();
    check_val("t1_lat_pre", start, 32'd0);
    tick();
    check_val("t1_lat_e6", start, 32'd1);
    check_val("t1_lock", door_lock, 32'd1);
    tick();
    check_val("t1_start_2nd", start, 32'd1);
    done = 1'b0;
    tick();
    check_val("t1_start_len2", start, 32'd0);
    check_val("t1_run_lock", door_lock, 32'd1);
    check_val("t1_run_dw", double_wash, 32'd1);
    tick();
    btn_start = 1'b0;
    repeat (500) tick();
    check_val("t1_run500_lock", door_lock, 32'd1);
    check_val("t1_run500_beep", finish_beep, 32'd0);
    done = 1'b1;
    tick();
    check_val("t1_beep_on", finish_beep, 32'd1);
    check_val("t1_beep_unlock", door_lock, 32'd0);
    beep_n = 1;
    for (int j = 0; j < 14; j++) begin
      tick();
      if (finish_beep === 1'b1) beep_n++;
    end
    check_val("t1_beep_len", beep_n, 32'd10);
    check_idle("t1_end");

    // Short glitches on btn_start are rejected; a 4-cycle pulse is accepted.
    hits = 0;
    for (int k = 0; k < 2; k++) begin
      btn_start = 1'b1;
      for (int j = 0; j < 11; j++) begin
        if (j == 3) btn_start = 1'b0;
        tick();
        if (start === 1'b1) hits++;
      end
    end
    check_val("t2_glitch_hits", hits, 32'd0);
    hits = 0;
    btn_start = 1'b1;
    for (int j = 0; j < 14; j++) begin
      if (j == 4) btn_start = 1'b0;
      tick();
      if (start === 1'b1) begin
        hits++;
        done = 1'b0;
      end
    end
    check_val("t2_pulse4_hits", hits, 32'd1);
    check_val("t2_run_lock", door_lock, 32'd1);
    done = 1'b1;
    repeat (12) tick();
    check_idle("t2_end");

    // Pause toggling; option switch changes are ignored mid-cycle.
    launch_run("t3");
    btn_pause = 1'b1;
    sw_double = 1'b0;
    repeat (6) tick();
    check_val("t3_pause_pre", time_pause, 32'd0);
    tick();
    check_val("t3_pause_on", time_pause, 32'd1);
    check_val("t3_pause_lock", door_lock, 32'd1);
    btn_pause = 1'b0;
    repeat (10) tick();
    check_val("t3_pause_hold", time_pause, 32'd1);
    check_val("t3_opt_frozen", double_wash, 32'd1);
    btn_pause = 1'b1;
    repeat (7) tick();
    check_val("t3_resume", time_pause, 32'd0);
    check_val("t3_resume_lock", door_lock, 32'd1);
    btn_pause = 1'b0;
    repeat (10) tick();
    done = 1'b1;
    repeat (12) tick();
    check_idle("t3_end");
    check_val("t3_opt_track", double_wash, 32'd0);

    // Launch timeout while done stays high.
    btn_start = 1'b1;
    wait_start("t4", 12);
    n = 0;
    while ((start === 1'b1) && (n < 20)) begin
      n++;
      tick();
    end
    check_val("t4_start_len", n, 32'd8);
    check_val("t4_fault", fault, 32'd1);
    check_val("t4_unlock", door_lock, 32'd0);
    check_val("t4_start_off", start, 32'd0);
    btn_start = 1'b0;
    repeat (10) tick();
    check_val("t4_fault_hold", fault, 32'd1);
    btn_start = 1'b1;
    repeat (6) tick();
    check_val("t4_fault_pre", fault, 32'd1);
    tick();
    check_val("t4_fault_clr", fault, 32'd0);
    check_val("t4_clr_start", start, 32'd0);
    repeat (3) tick();
    btn_start = 1'b0;
    repeat (10) tick();
    check_val("t4_no_relaunch", start, 32'd0);
    check_idle("t4_end");

    // done rising together with a pause press in RUN goes to FINISH.
    launch_run("t5");
    btn_pause = 1'b1;
    repeat (6) tick();
    done = 1'b1;
    tick();
    check_val("t5_collide_tp", time_pause, 32'd0);
    check_val("t5_collide_beep", finish_beep, 32'd1);
    btn_pause = 1'b0;
    repeat (12) tick();
    check_idle("t5a_end");

    // Start and pause pressed together in IDLE: start wins.
    btn_start = 1'b1;
    btn_pause = 1'b1;
    repeat (7) tick();
    check_val("t5_dual_start", start, 32'd1);
    check_val("t5_dual_tp", time_pause, 32'd0);
    done = 1'b0;
    tick();
    btn_start = 1'b0;
    btn_pause = 1'b0;
    check_val("t5_dual_run_lock", door_lock, 32'd1);
    repeat (10) tick();
    check_val("t5_dual_run_tp", time_pause, 32'd0);
    done = 1'b1;
    repeat (12) tick();
    check_idle("t5b_end");

    // Reset while paused.
    launch_run("t6");
    btn_pause = 1'b1;
    repeat (7) tick();
    check_val("t6_paused", time_pause, 32'd1);
    btn_pause = 1'b0;
    sw_double = 1'b1;
    sw_dry    = 1'b1;
    repeat (10) tick();
    check_val("t6_frozen", double_wash, 32'd0);
    rst_n = 1'b0;
    tick();
    check_all_zero("t6_rst");
    rst_n = 1'b1;
    done  = 1'b1;
    repeat (8) tick();
    check_val("t6_dw_track", double_wash, 32'd1);
    check_val("t6_dry_track", dry_wash, 32'd1);
    check_idle("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
